// File: rtl/divu_pkg.sv
// Shared definitions for the sequential unsigned divider: state encoding,
// default widths and a small sizing helper.
package divu_pkg;

    localparam int DIVU_DW_DEF = 8;
    localparam int DIVU_VW_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } divu_state_e;

    // Width of a down-counter that must hold the value n.
    function automatic int divu_cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/divu_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder and subtract the divisor when it fits.
module divu_step #(
    parameter int VW = 4
) (
    input  logic [VW-1:0] rem_in,
    input  logic          bit_in,
    input  logic [VW-1:0] divisor,
    output logic [VW-1:0] rem_out,
    output logic          q_bit
);

    logic [VW:0] trial_s;

    // Conditional subtract on the VW+1-bit shifted partial remainder.
    always_comb begin
        trial_s = {rem_in, bit_in};
        if (trial_s >= {1'b0, divisor}) begin
            q_bit   = 1'b1;
            rem_out = VW'(trial_s - {1'b0, divisor});
        end else begin
            q_bit   = 1'b0;
            rem_out = trial_s[VW-1:0];
        end
    end

endmodule

// File: rtl/divu_seq.sv
// Sequential unsigned restoring divider, one quotient bit per cycle.
// Optional build macro: DIVU_FAST_EXIT_EN -- when defined, a zero divisor or
// a dividend smaller than the divisor finishes one cycle after acceptance.
// Results are identical with or without the macro; only latency differs.
module divu_seq
    import divu_pkg::*;
#(
    parameter int DW = DIVU_DW_DEF,
    parameter int VW = DIVU_VW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_by_zero
);

    localparam int CW = divu_cnt_width(DW);

    divu_state_e   state_r;
    divu_state_e   state_nx_s;
    logic [CW-1:0] cnt_r;
    logic [DW-1:0] q_sh_r;
    logic [VW-1:0] rem_r;
    logic [VW-1:0] dvsr_r;
    logic          accept_s;
    logic [VW-1:0] step_rem_s;
    logic          step_bit_s;
    logic          busy_nx_s;
    logic          done_nx_s;
    logic          busy_r;
    logic          done_r;
    logic [DW-1:0] quotient_r;
    logic [VW-1:0] remainder_r;
    logic          dbz_r;

`ifdef DIVU_FAST_EXIT_EN
    logic          fast_s;
    assign fast_s = (divisor == {VW{1'b0}}) || (dividend < DW'(divisor));
`endif

    divu_step #(.VW(VW)) u_step (
        .rem_in  (rem_r),
        .bit_in  (q_sh_r[DW-1]),
        .divisor (dvsr_r),
        .rem_out (step_rem_s),
        .q_bit   (step_bit_s)
    );

    // A new request is only taken when no division is in flight.
    always_comb begin
        accept_s = 1'b0;
        if (start && ((state_r == ST_IDLE) || (state_r == ST_DONE))) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic: RUN ends once the counter has reached zero.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) state_nx_s = ST_RUN;
                else          state_nx_s = ST_IDLE;
            end
            ST_RUN: begin
                if (cnt_r == {CW{1'b0}}) state_nx_s = ST_DONE;
                else                     state_nx_s = ST_RUN;
            end
            ST_DONE: begin
                if (accept_s) state_nx_s = ST_RUN;
                else          state_nx_s = ST_IDLE;
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // Output decode from the upcoming state so busy/done come out of flops.
    always_comb begin
        busy_nx_s = 1'b0;
        done_nx_s = 1'b0;
        case (state_nx_s)
            ST_RUN:  busy_nx_s = 1'b1;
            ST_DONE: done_nx_s = 1'b1;
            default: begin
                busy_nx_s = 1'b0;
                done_nx_s = 1'b0;
            end
        endcase
    end

    // Datapath: operand capture, shift-subtract iterations, result latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r       <= {CW{1'b0}};
            q_sh_r      <= {DW{1'b0}};
            rem_r       <= {VW{1'b0}};
            dvsr_r      <= {VW{1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            quotient_r  <= {DW{1'b0}};
            remainder_r <= {VW{1'b0}};
            dbz_r       <= 1'b0;
        end else begin
            if (accept_s) begin
                dvsr_r <= divisor;
`ifdef DIVU_FAST_EXIT_EN
                if (fast_s) begin
                    // Answer is known up front; RUN lasts a single cycle.
                    if (divisor == {VW{1'b0}}) begin
                        q_sh_r <= {DW{1'b1}};
                        rem_r  <= {VW{1'b0}};
                    end else begin
                        q_sh_r <= {DW{1'b0}};
                        rem_r  <= dividend[VW-1:0];
                    end
                    cnt_r <= {CW{1'b0}};
                end else begin
                    q_sh_r <= dividend;
                    rem_r  <= {VW{1'b0}};
                    cnt_r  <= CW'(DW);
                end
`else
                q_sh_r <= dividend;
                rem_r  <= {VW{1'b0}};
                cnt_r  <= CW'(DW);
`endif
            end else if (state_r == ST_RUN) begin
                if (cnt_r != {CW{1'b0}}) begin
                    // Dividend bits leave the top of q_sh while quotient bits enter the bottom.
                    rem_r  <= step_rem_s;
                    q_sh_r <= {q_sh_r[DW-2:0], step_bit_s};
                    cnt_r  <= cnt_r - CW'(1);
                end else begin
                    quotient_r <= q_sh_r;
                    if (dvsr_r == {VW{1'b0}}) begin
                        remainder_r <= {VW{1'b0}};
                        dbz_r       <= 1'b1;
                    end else begin
                        remainder_r <= rem_r;
                        dbz_r       <= 1'b0;
                    end
                end
            end else begin
                cnt_r <= cnt_r;
            end
            busy_r <= busy_nx_s;
            done_r <= done_nx_s;
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign quotient    = quotient_r;
    assign remainder   = remainder_r;
    assign div_by_zero = dbz_r;

endmodule
